// File: rtl/apb_master_bridge.sv
// APB initiator bridging a one-outstanding request/response port onto NUM_SLV APB slots.
// Optional ACCESS-phase timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int          NUM_SLV     = 4,
  parameter logic [15:0] BASE_HI     = 16'h1000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_transfer,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic [31:0]           PADDR,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  output logic                  PENABLE,
  output logic [NUM_SLV-1:0]    PSEL,
  input  logic [NUM_SLV*32-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]    PREADY
);

  localparam logic [4:0] NUM_SLV_W = 5'(NUM_SLV);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t               state_q, state_d;
  logic [3:0]           slot_q, slot_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_error_q, rsp_error_d;
  logic [31:0]          paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic                 penable_q, penable_d;
  logic [NUM_SLV-1:0]   psel_q, psel_d;

  logic                 hit;
  logic [NUM_SLV-1:0]   psel_dec;
  logic                 pready_sel;
  logic [31:0]          prdata_sel;
  logic                 tmo_hit;

  // Only the latched slot's PREADY/PRDATA are observed; other slots are ignored.
  always_comb begin
    pready_sel = 1'b0;
    prdata_sel = '0;
    psel_dec   = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (slot_q == 4'(i)) begin
        pready_sel = PREADY[i];
        prdata_sel = PRDATA[32*i +: 32];
      end
      psel_dec[i] = (req_addr[15:12] == 4'(i));
    end
    hit = (req_addr[31:16] == BASE_HI) && ({1'b0, req_addr[15:12]} < NUM_SLV_W);
  end

`ifdef APB_MASTER_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  // Held at zero outside a transfer, so it is clear on entry to SETUP.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_IDLE)
      tmo_cnt_d = '0;
    else if (state_q == ST_ACCESS)
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    tmo_hit = (state_q == ST_ACCESS) && (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic [15:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 16'(TIMEOUT_CYC);
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_transfer) begin
          if (hit) begin
            state_d  = ST_SETUP;
            slot_d   = req_addr[15:12];
            paddr_d  = req_addr;
            pwrite_d = req_write;
            pwdata_d = req_wdata;
            psel_d   = psel_dec;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        // A PREADY coinciding with the timeout limit completes normally.
        if (pready_sel || tmo_hit) begin
          state_d     = ST_IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = !pready_sel;
          rsp_rdata_d = (pready_sel && !pwrite_q) ? prdata_sel : 32'h0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      penable_q   <= 1'b0;
      psel_q      <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      penable_q   <= penable_d;
      psel_q      <= psel_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PENABLE   = penable_q;
  assign PSEL      = psel_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: slot0/3 zero-wait, slot1 registered PREADY, slot2 never ready.
module tb_apb_master_bridge;

  logic         PCLK = 1'b0;
  logic         PRESET = 1'b1;
  logic         req_transfer = 1'b0;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic         req_ready, rsp_valid, rsp_error;
  logic [31:0]  rsp_rdata, PADDR, PWDATA;
  logic         PWRITE, PENABLE;
  logic [3:0]   PSEL;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY;
  logic         slv1_rdy;

  int checks = 0;
  int errors = 0;
  int n;
  int pulses;
  int errs_seen;

  apb_master_bridge #(.NUM_SLV(4), .BASE_HI(16'h1000), .TIMEOUT_CYC(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_transfer(req_transfer), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Registered-PREADY slave: answers the cycle after it first sees PSEL&PENABLE.
  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) slv1_rdy <= 1'b0;
    else        slv1_rdy <= PSEL[1] & PENABLE & ~slv1_rdy;
  end

  assign PRDATA = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
  assign PREADY = {1'b1, 1'b0, slv1_rdy, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a request at a negedge; returns at the negedge after the accept edge with n=1.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge PCLK);
    chk("req_ready_before_issue", {31'b0, req_ready}, 32'd1);
    req_write = w; req_addr = a; req_wdata = d; req_transfer = 1'b1;
    @(negedge PCLK);
    req_transfer = 1'b0;
    n = 1;
  endtask

  task automatic wait_rsp(input int limit);
    while (rsp_valid !== 1'b1 && n < limit) begin
      @(negedge PCLK);
      n++;
    end
    if (rsp_valid !== 1'b1) chk("rsp_valid_timeout", {31'b0, rsp_valid}, 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_psel", {28'b0, PSEL}, 32'h0);
    chk("rst_penable", {31'b0, PENABLE}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    @(negedge PCLK);
    PRESET = 1'b0;

    // Write to slot 1 (registered PREADY)
    issue(1'b1, 32'h1000_1000, 32'h0000_04D2);
    chk("wr_setup_psel", {28'b0, PSEL}, 32'h2);
    chk("wr_setup_penable", {31'b0, PENABLE}, 32'h0);
    chk("wr_pwdata", PWDATA, 32'h0000_04D2);
    chk("wr_paddr", PADDR, 32'h1000_1000);
    chk("wr_pwrite", {31'b0, PWRITE}, 32'h1);
    chk("wr_busy_ready", {31'b0, req_ready}, 32'h0);
    @(negedge PCLK); n++;
    chk("wr_access_penable", {31'b0, PENABLE}, 32'h1);
    chk("wr_access_psel", {28'b0, PSEL}, 32'h2);
    wait_rsp(40);
    chk("wr_latency", n, 32'd4);
    chk("wr_rsp_error", {31'b0, rsp_error}, 32'h0);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    chk("wr_done_psel", {28'b0, PSEL}, 32'h0);
    chk("wr_done_ready", {31'b0, req_ready}, 32'h1);
    @(negedge PCLK);
    chk("wr_pulse_end", {31'b0, rsp_valid}, 32'h0);
    chk("wr_rdata_idle", rsp_rdata, 32'h0);

    // Reads: zero-wait slot 0 and 3, registered slot 1
    issue(1'b0, 32'h1000_0000, 32'h0);
    wait_rsp(40);
    chk("rd0_latency", n, 32'd3);
    chk("rd0_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd0_error", {31'b0, rsp_error}, 32'h0);
    issue(1'b0, 32'h1000_3004, 32'h0);
    wait_rsp(40);
    chk("rd3_latency", n, 32'd3);
    chk("rd3_rdata", rsp_rdata, 32'h3333_3333);
    issue(1'b0, 32'h1000_1008, 32'h0);
    wait_rsp(40);
    chk("rd1_latency", n, 32'd4);
    chk("rd1_rdata", rsp_rdata, 32'h1111_1111);

    // Decode misses: PADDR keeps the last hit address
    issue(1'b0, 32'h2000_0000, 32'h0);
    chk("miss_a_psel", {28'b0, PSEL}, 32'h0);
    wait_rsp(5);
    chk("miss_a_latency", n, 32'd1);
    chk("miss_a_error", {31'b0, rsp_error}, 32'h1);
    chk("miss_a_rdata", rsp_rdata, 32'h0);
    chk("miss_a_paddr", PADDR, 32'h1000_1008);
    issue(1'b0, 32'h1000_5000, 32'h0);
    wait_rsp(5);
    chk("miss_b_latency", n, 32'd1);
    chk("miss_b_error", {31'b0, rsp_error}, 32'h1);
    chk("miss_b_psel", {28'b0, PSEL}, 32'h0);
    issue(1'b0, 32'h1000_4000, 32'h0);
    wait_rsp(5);
    chk("miss_c_error", {31'b0, rsp_error}, 32'h1);
    issue(1'b0, 32'h1001_0000, 32'h0);
    wait_rsp(5);
    chk("miss_d_error", {31'b0, rsp_error}, 32'h1);
    @(negedge PCLK);

    // req_transfer held through two hits; address changes while busy are not captured
    req_write = 1'b0; req_addr = 32'h1000_0000; req_transfer = 1'b1;
    pulses = 0; errs_seen = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge PCLK);
      if (k == 1) begin
        req_addr = 32'h1000_3000;
        chk("b2b_first_psel", {28'b0, PSEL}, 32'h1);
      end
      if (k == 3) chk("b2b_first_rdata", rsp_rdata, 32'hDEAD_BEEF);
      if (k == 4) begin
        chk("b2b_second_psel", {28'b0, PSEL}, 32'h8);
        req_transfer = 1'b0;
      end
      if (k == 6) chk("b2b_second_rdata", rsp_rdata, 32'h3333_3333);
      if (rsp_valid === 1'b1) pulses++;
      if (rsp_error === 1'b1) errs_seen++;
    end
    chk("b2b_pulses", pulses, 32'd2);
    chk("b2b_errors", errs_seen, 32'd0);

    // Async reset while slot 2 stalls in ACCESS
    issue(1'b0, 32'h1000_2000, 32'h0);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_mid_access", {27'b0, PENABLE, PSEL}, 32'h14);
    PRESET = 1'b1;
    #1;
    chk("rst_mid_psel", {28'b0, PSEL}, 32'h0);
    chk("rst_mid_penable", {31'b0, PENABLE}, 32'h0);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'h1);
    @(negedge PCLK);
    PRESET = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      if (rsp_valid === 1'b1) pulses++;
    end
    chk("rst_no_rsp", pulses, 32'd0);
    issue(1'b0, 32'h1000_0000, 32'h0);
    wait_rsp(40);
    chk("post_rst_latency", n, 32'd3);
    chk("post_rst_rdata", rsp_rdata, 32'hDEAD_BEEF);

    // Slot 2 never ready
    issue(1'b0, 32'h1000_2000, 32'h0);
`ifdef APB_MASTER_TIMEOUT_EN
    for (int k = 2; k <= 17; k++) @(negedge PCLK);
    chk("tmo_last_access", {27'b0, PENABLE, PSEL}, 32'h14);
    chk("tmo_not_yet", {31'b0, rsp_valid}, 32'h0);
    @(negedge PCLK);
    chk("tmo_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("tmo_rsp_error", {31'b0, rsp_error}, 32'h1);
    chk("tmo_rdata", rsp_rdata, 32'h0);
    chk("tmo_psel", {27'b0, PENABLE, PSEL}, 32'h0);
`else
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge PCLK);
      if (rsp_valid === 1'b1) pulses++;
    end
    chk("stall_still_access", {27'b0, PENABLE, PSEL}, 32'h14);
    chk("stall_no_rsp", pulses, 32'd0);
    chk("stall_not_ready", {31'b0, req_ready}, 32'h0);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
`endif
    issue(1'b1, 32'h1000_3010, 32'hCAFE_0001);
    wait_rsp(40);
    chk("final_latency", n, 32'd3);
    chk("final_wr_rdata", rsp_rdata, 32'h0);
    chk("final_wr_error", {31'b0, rsp_error}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
